// File: rtl/adrv9001_enable_seq.sv
// ADRV9001 TX/RX enable sequencer: arbitrates burst requests and sequences
// the radio enable pins through setup, on and guard phases.
// Ports: clk, rst (sync, active-high), enable, tx_req, rx_req,
//   tx/rx_setup_cycles, guard_cycles (delay loads);
//   tx_en, rx_en, tx_valid, rx_valid, busy, conflict (pulse),
//   tx_bursts, rx_bursts (wrapping burst counters).
module adrv9001_enable_seq #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               tx_req,
  input  logic               rx_req,
  input  logic [CNT_W-1:0]   tx_setup_cycles,
  input  logic [CNT_W-1:0]   rx_setup_cycles,
  input  logic [CNT_W-1:0]   guard_cycles,
  output logic               tx_en,
  output logic               rx_en,
  output logic               tx_valid,
  output logic               rx_valid,
  output logic               busy,
  output logic               conflict,
  output logic [BURST_W-1:0] tx_bursts,
  output logic [BURST_W-1:0] rx_bursts
);

  localparam int S_IDLE  = 0;
  localparam int S_TXS   = 1;
  localparam int S_TXON  = 2;
  localparam int S_RXS   = 3;
  localparam int S_RXON  = 4;
  localparam int S_GUARD = 5;

  typedef enum logic [5:0] {
    IDLE     = 6'b000001,
    TX_SETUP = 6'b000010,
    TX_ON    = 6'b000100,
    RX_SETUP = 6'b001000,
    RX_ON    = 6'b010000,
    GUARD    = 6'b100000
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               conflict_nx;
  logic               tx_inc, rx_inc;
  logic               cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      conflict  <= 1'b0;
      tx_bursts <= '0;
      rx_bursts <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      conflict <= conflict_nx;
      if (tx_inc) tx_bursts <= tx_bursts + 1'b1;
      if (rx_inc) rx_bursts <= rx_bursts + 1'b1;
    end
  end

  // Delay inputs are only looked at when the countdown is loaded.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    conflict_nx = 1'b0;
    tx_inc      = 1'b0;
    rx_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && tx_req) begin
          state_nx    = TX_SETUP;
          cnt_nx      = tx_setup_cycles;
          conflict_nx = rx_req;
        end else if (enable && rx_req) begin
          state_nx = RX_SETUP;
          cnt_nx   = rx_setup_cycles;
        end
      end
      TX_SETUP: begin
        if (!tx_req || !enable) begin
          state_nx = GUARD;
          cnt_nx   = guard_cycles;
        end else if (cnt_zero) begin
          state_nx = TX_ON;
          tx_inc   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      TX_ON: begin
        if (!tx_req || !enable) begin
          state_nx = GUARD;
          cnt_nx   = guard_cycles;
        end
      end
      RX_SETUP: begin
        if (!rx_req || !enable) begin
          state_nx = GUARD;
          cnt_nx   = guard_cycles;
        end else if (cnt_zero) begin
          state_nx = RX_ON;
          rx_inc   = 1'b1;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      RX_ON: begin
        if (!rx_req || !enable) begin
          state_nx = GUARD;
          cnt_nx   = guard_cycles;
        end
      end
      GUARD: begin
        if (cnt_zero) state_nx = IDLE;
        else          cnt_nx   = cnt - 1'b1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs come straight from the one-hot state bits.
  assign tx_en    = state[S_TXS] | state[S_TXON];
  assign rx_en    = state[S_RXS] | state[S_RXON];
  assign tx_valid = state[S_TXON];
  assign rx_valid = state[S_RXON];
  assign busy     = ~state[S_IDLE];

  logic unused_guard_bit;
  assign unused_guard_bit = state[S_GUARD];

endmodule
